fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 64x16 RAM (RAM_64) and downstream of the program loader.
- In IDLE it writes a program into RAM sequentially from the load port.
- After START it fetches 16-bit words at PC and hands them to decode through a valid/ready handshake.
- Supports branch redirect/flush and halts on the HALT opcode.

Parameters:
- AW, 6, address width (64 words).
- DW, 16, data/instruction width.
- HALT_OP, 16'hFFFF, opcode that stops fetching.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  pulse; IDLE -> RUN, PC=0.
- LD_VALID  in  1  load-word strobe (honoured in IDLE only).
- LD_DATA  in  DW  word to load.
- LD_FULL  out  1  64 words loaded; further loads ignored.
- MEM_ADDR  out  AW  to RAM ADDR.
- MEM_D  out  DW  to RAM D (equals LD_DATA).
- MEM_W  out  1  to RAM W.
- MEM_R  out  1  to RAM R.
- MEM_E  out  1  to RAM E.
- MEM_Q  in  DW  from RAM OUT; combinational, valid in the same cycle as MEM_R/MEM_E/MEM_ADDR.
- BR_TAKEN  in  1  redirect request from execute.
- BR_TARGET  in  AW  redirect address.
- IR  out  DW  fetched instruction.
- IR_PC  out  AW  address of IR.
- IR_VALID  out  1  IR holds a valid instruction.
- IR_READY  in  1  decode accepts IR this cycle.
- HALTED  out  1  HALT state.

Behaviour:
- Reset (RST=1 at edge, overrides all inputs):
  - state=IDLE; PC=0; LD_PTR=0.
  - LD_FULL=0, IR=0, IR_PC=0, IR_VALID=0, HALTED=0.
  - Mid-load or mid-run reset discards everything in flight. RAM contents are not cleared.
- States: IDLE, RUN, HALT.
- IDLE, load:
  - ld_fire = LD_VALID & !LD_FULL.
  - MEM_W=MEM_E=ld_fire, MEM_R=0, MEM_ADDR=LD_PTR. RAM writes on the same edge.
  - On ld_fire: LD_PTR+1. If LD_PTR==63, LD_FULL<=1 and LD_PTR wraps to 0.
  - LD_VALID while LD_FULL=1, or outside IDLE, is ignored (MEM_W=0).
- IDLE -> RUN on START:
  - PC<=0.
  - START and LD_VALID in the same cycle: the load completes and the state changes on the same edge.
  - START outside IDLE is ignored.
- RUN:
  - fire = !BR_TAKEN & (!IR_VALID | IR_READY).
  - MEM_R=MEM_E=fire, MEM_W=0, MEM_ADDR=PC.
  - On fire: IR<=MEM_Q, IR_PC<=PC, IR_VALID<=1, PC<=PC+1 (mod 64, 63->0).
  - Zero-bubble throughput: one instruction per cycle while IR_READY=1.
  - IR_VALID & !IR_READY: IR, IR_PC and PC hold, and the RAM is not read.
  - BR_TAKEN (priority over fire): PC<=BR_TARGET and IR_VALID<=0, regardless of IR_READY. The first target word appears in IR one cycle later. Back-to-back BR_TAKEN: the last target wins, with no fetch between.
- HALT entry:
  - When fire captures MEM_Q==HALT_OP: state<=HALT, HALTED<=1.
  - The HALT word itself is presented with IR_VALID=1.
  - A BR_TAKEN in the cycle after capture is ignored.
- HALT:
  - No fetch; MEM_R=MEM_E=MEM_W=0.
  - IR_VALID clears on the IR_READY handshake.
  - BR_TAKEN, START and LD_VALID are ignored. Only RST exits.
- Memory interface:
  - All MEM_* outputs are combinational from state/inputs.
  - MEM_R and MEM_W are never both 1.
  - MEM_E=0 whenever neither is asserted.
- Latency: PC-to-IR is 1 cycle. Branch-to-IR_VALID of the target is 1 cycle after the flush cycle.

Test Plan:
- Load then run:
  - Stimulus: load 16'h1111, 16'h2222, 16'h3333; START; IR_READY=1.
  - Required: MEM_W pulses at ADDR 0,1,2. After START, IR = 1111/2222/3333 on consecutive cycles with IR_PC = 0,1,2.
- Backpressure:
  - Stimulus: IR_READY=0 for 3 cycles with IR=2222.
  - Required: IR, IR_PC=1 and PC=2 held; MEM_R=0. Release gives 3333 next cycle with no skipped or duplicated word.
- Branch flush:
  - Stimulus: BR_TAKEN=1, BR_TARGET=6'd40 while IR_VALID=1, IR_READY=0.
  - Required: next cycle IR_VALID=0; following cycle IR=RAM[40], IR_PC=40. Two consecutive branches (40 then 10): IR_PC=10 first.
- Wrap and full:
  - Stimulus: load 64 words.
  - Required: LD_FULL=1 after the 64th; the 65th LD_VALID gives MEM_W=0. Run from PC=62 (via branch): IR_PC sequence 62, 63, 0.
- Halt:
  - Stimulus: RAM[2]=16'hFFFF.
  - Required: IR=FFFF with IR_PC=2 and HALTED=1; no MEM_R afterwards; BR_TAKEN ignored; IR_VALID drops after the handshake.
- Reset mid-run:
  - Stimulus: RST during a fetch stream with IR_VALID=1.
  - Required: next cycle IR_VALID=0, HALTED=0, LD_FULL=0, state IDLE. Reload is not required; START re-fetches from address 0 with the old RAM contents.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: loads a program into the 64x16 RAM while idle, then
// streams words at PC to decode over a valid/ready handshake until HALT_OP.
module fetch_unit #(
    parameter int unsigned       AW      = 6,
    parameter int unsigned       DW      = 16,
    parameter logic [DW-1:0]     HALT_OP = 16'hFFFF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          ld_valid_i,
    input  logic [DW-1:0] ld_data_i,
    output logic          ld_full_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_d_o,
    output logic          mem_w_o,
    output logic          mem_r_o,
    output logic          mem_e_o,
    input  logic [DW-1:0] mem_q_i,
    input  logic          br_taken_i,
    input  logic [AW-1:0] br_target_i,
    output logic [DW-1:0] ir_o,
    output logic [AW-1:0] ir_pc_o,
    output logic          ir_valid_o,
    input  logic          ir_ready_i,
    output logic          halted_o
);

    // state  | meaning
    // S_IDLE | accept load words into RAM, wait for start
    // S_RUN  | fetch at PC into IR, honour backpressure and redirects
    // S_HALT | HALT word captured; no further fetches until reset
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ld_ptr_q, ld_ptr_d;
    logic          ld_full_q, ld_full_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;
    logic          ld_fire;
    logic          fetch_fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ld_ptr_q   <= '0;
            ld_full_q  <= 1'b0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ld_ptr_q   <= ld_ptr_d;
            ld_full_q  <= ld_full_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ld_ptr_d   = ld_ptr_q;
        ld_full_d  = ld_full_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        ld_fire    = 1'b0;
        fetch_fire = 1'b0;
        mem_addr_o = '0;

        case (state_q)
            S_IDLE: begin
                mem_addr_o = ld_ptr_q;
                ld_fire    = ld_valid_i & ~ld_full_q;
                if (ld_fire) begin
                    ld_ptr_d = ld_ptr_q + 1'b1;
                    if (ld_ptr_q == '1) begin
                        ld_full_d = 1'b1;
                    end
                end
                if (start_i) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                mem_addr_o = pc_q;
                fetch_fire = ~br_taken_i & (~ir_valid_q | ir_ready_i);
                // A redirect flushes IR even when decode is stalled.
                if (br_taken_i) begin
                    pc_d       = br_target_i;
                    ir_valid_d = 1'b0;
                end else if (fetch_fire) begin
                    ir_d       = mem_q_i;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + 1'b1;
                    if (mem_q_i == HALT_OP) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (ir_ready_i) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_w_o    = ld_fire;
    assign mem_r_o    = fetch_fire;
    assign mem_e_o    = ld_fire | fetch_fire;
    assign mem_d_o    = ld_data_i;
    assign ld_full_o  = ld_full_q;
    assign ir_o       = ir_q;
    assign ir_pc_o    = ir_pc_q;
    assign ir_valid_o = ir_valid_q;
    assign halted_o   = (state_q == S_HALT);

endmodule
